// File: rtl/spi_pkg.sv
// Shared types and default sizes for the SPI master and its clock generator.
package spi_pkg;

  localparam int DEF_DWIDTH  = 8;
  localparam int DEF_AWIDTH  = 7;
  localparam int DEF_NSLAVES = 4;
  localparam int FRAME_W     = 1 + DEF_AWIDTH + DEF_DWIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cphase;
  } mode_t;

endpackage

// File: rtl/spi_clkgen.sv
// SCK timing: half-period down-counter plus edge counter.
// lead/trail strobes fire in the clk cycle whose closing edge moves SCK;
// done fires when the post-transfer hold half period expires.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int DIVW  = 8,
  parameter int NBITS = FRAME_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            active_i,
  input  logic [DIVW-1:0] div_i,
  output logic            lead_stb_o,
  output logic            trail_stb_o,
  output logic            last_edge_o,
  output logic            done_o
);

  localparam int            EW    = $clog2(2 * NBITS + 1);
  localparam logic [EW-1:0] EDGES = EW'(2 * NBITS);

  logic [DIVW-1:0] div_q, div_d;
  logic [DIVW-1:0] hp_q, hp_d;
  logic [EW-1:0]   ec_q, ec_d;
  logic            tick;
  logic            edge_stb;

  assign tick        = active_i && (hp_q == '0);
  assign edge_stb    = tick && (ec_q != EDGES);
  assign lead_stb_o  = edge_stb && !ec_q[0];
  assign trail_stb_o = edge_stb && ec_q[0];
  assign last_edge_o = edge_stb && (ec_q == EDGES - EW'(1));
  assign done_o      = tick && (ec_q == EDGES);

  // Counter next-state: reload on accept and on every half-period expiry.
  always_comb begin
    div_d = div_q;
    hp_d  = hp_q;
    ec_d  = ec_q;
    if (load_i) begin
      div_d = div_i;
      hp_d  = div_i;
      ec_d  = '0;
    end else if (tick) begin
      hp_d = div_q;
      if (edge_stb) ec_d = ec_q + EW'(1);
    end else if (active_i) begin
      hp_d = hp_q - DIVW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      hp_q  <= '0;
      ec_q  <= '0;
    end else begin
      div_q <= div_d;
      hp_q  <= hp_d;
      ec_q  <= ec_d;
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: one {rw, addr, data} frame per accepted command,
// any CPOL/CPHA mode, runtime divider, chip-select decode and read-back.
//
// state | meaning
// IDLE  | ready for a command; sck follows cfg_mode[1], ss_n all ones
// SETUP | chip select asserted, one half period before the first edge
// XFER  | 2N SCK edges, shifting mosi and sampling miso
// HOLD  | one half period after the last edge, then release ss_n
module spi_master_gen
  import spi_pkg::*;
#(
  parameter int  DWIDTH  = DEF_DWIDTH,
  parameter int  AWIDTH  = DEF_AWIDTH,
  parameter int  NSLAVES = DEF_NSLAVES,
  parameter int  DIVW    = 8,
  localparam int SW      = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  input  logic [SW-1:0]     cmd_slave,
  input  logic [1:0]        cfg_mode,
  input  logic [DIVW-1:0]   cfg_div,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NSLAVES-1:0] ss_n
);

  localparam int N = 1 + AWIDTH + DWIDTH;

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [N-1:0]       tx_q, tx_d;
  logic [DWIDTH-1:0]  rx_q, rx_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic [NSLAVES-1:0] ss_n_q, ss_n_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               err_q, err_d;

  logic               accept;
  logic               lead_stb, trail_stb, last_edge, done;
  logic               drive, sample;
  logic [N-1:0]       frame;
  logic [NSLAVES-1:0] ss_sel;

  assign accept    = cmd_valid && (state_q == IDLE);
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign ss_n      = ss_n_q;

  spi_clkgen #(
    .DIVW  (DIVW),
    .NBITS (N)
  ) u_clkgen (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .active_i    (state_q != IDLE),
    .div_i       (cfg_div),
    .lead_stb_o  (lead_stb),
    .trail_stb_o (trail_stb),
    .last_edge_o (last_edge),
    .done_o      (done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept)    state_d = SETUP;
      SETUP: if (lead_stb)  state_d = XFER;
      XFER:  if (last_edge) state_d = HOLD;
      HOLD:  if (done)      state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Frame assembly and chip-select decode from the live command fields;
  // an out-of-range slave index matches no bit, so nothing is selected.
  always_comb begin
    frame  = {cmd_rw, cmd_addr, (cmd_rw ? {DWIDTH{1'b0}} : cmd_wdata)};
    ss_sel = '1;
    for (int i = 0; i < NSLAVES; i++) ss_sel[i] = (cmd_slave != SW'(i));
  end

  // Output and datapath next-state.
  always_comb begin
    mode_d      = mode_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    ss_n_d      = ss_n_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_d       = err_q;
    drive       = 1'b0;
    sample      = 1'b0;
    if (state_q == IDLE) begin
      sck_d  = cfg_mode[1];
      mosi_d = 1'b0;
      if (accept) begin
        mode_d = mode_t'(cfg_mode);
        err_d  = (int'(cmd_slave) >= NSLAVES);
        ss_n_d = ss_sel;
        if (cfg_mode[0]) begin
          // CPHA=1 puts the first bit out on the first edge.
          tx_d = frame;
        end else begin
          mosi_d = frame[N-1];
          tx_d   = frame << 1;
        end
      end
    end else begin
      sck_d  = (state_q == XFER) ? sck_q : mode_q.cpol;
      drive  = mode_q.cphase ? lead_stb : (trail_stb && !last_edge);
      sample = mode_q.cphase ? trail_stb : lead_stb;
      if (lead_stb || trail_stb) sck_d = ~sck_q;
      if (drive) begin
        mosi_d = tx_q[N-1];
        tx_d   = tx_q << 1;
      end
      if (sample) rx_d = DWIDTH'({rx_q, miso});
      if (done) begin
        sck_d       = cfg_mode[1];
        mosi_d      = 1'b0;
        ss_n_d      = '1;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rx_q;
        rsp_err_d   = err_q;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      ss_n_q      <= '1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      ss_n_q      <= ss_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
// Scoreboard bench for spi_master_gen: stimulus pushes expectations,
// a negedge monitor acts as the SPI slave and checks each response pulse.
module tb_spi_master_gen;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic [1:0] cmd_slave = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_div = '0;
  logic       cmd_ready, rsp_valid, rsp_err, busy, sck, mosi, miso;
  logic [7:0] rsp_rdata;
  logic [3:0] ss_n;
  logic       loop_en = 1'b0, miso_drv = 1'b0;
  assign miso = loop_en ? mosi : miso_drv;

  logic       c3_valid = 1'b0;
  logic [1:0] c3_slave = '0;
  logic       cmd_ready3, rsp_valid3, rsp_err3, busy3, sck3, mosi3;
  logic [7:0] rsp_rdata3;
  logic [2:0] ss_n3;

  spi_master_gen #(.DWIDTH(8), .AWIDTH(7), .NSLAVES(4), .DIVW(8)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_slave(cmd_slave), .cfg_mode(cfg_mode), .cfg_div(cfg_div),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n));

  spi_master_gen #(.DWIDTH(8), .AWIDTH(7), .NSLAVES(3), .DIVW(8)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(cmd_ready3),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_slave(c3_slave), .cfg_mode(cfg_mode), .cfg_div(cfg_div),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .busy(busy3), .sck(sck3), .mosi(mosi3), .miso(mosi3), .ss_n(ss_n3));

  typedef struct {
    logic [15:0] frame;
    logic [15:0] mframe;
    logic [7:0]  rdata;
    logic        err;
    int          lat;
    int          h;
    logic [1:0]  mode;
    logic [3:0]  ss;
  } exp_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp3_t;

  exp_t  sb[$];
  exp3_t sb3[$];
  int    acc_q[$];
  int    acc3_q[$];
  int    n_cmp = 0, n_fail = 0;
  int    cyc = 0;
  int    rsp_cnt = 0, done3 = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Accept timestamps, taken on the clock edge that registers the handshake.
  always @(posedge clk) begin
    if (!rst && cmd_valid && cmd_ready) acc_q.push_back(cyc);
    if (!rst && c3_valid && cmd_ready3) acc3_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  // Slave model and response checker for the 4-slave instance.
  int         ecnt = 0, first_e = -1, ss_bad = 0, j = 0, a = 0;
  logic [15:0] cap = '0;
  logic       sck_prev = 1'b0, cpha = 1'b0, lead = 1'b0;
  exp_t       e;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      acc_q.delete();
      ecnt = 0; first_e = -1; ss_bad = 0; cap = '0;
    end else begin
      if (sck !== sck_prev && ss_n !== 4'hF && sb.size() > 0) begin
        ecnt++;
        if (ecnt == 1) first_e = cyc;
        if (ss_n !== sb[0].ss) ss_bad++;
        lead = (ecnt % 2 == 1);
        cpha = sb[0].mode[0];
        if (cpha ? !lead : lead) cap = {cap[14:0], mosi};
        if (cpha ? lead : (!lead && ecnt < 2 * N)) begin
          j = cpha ? (ecnt - 1) / 2 : ecnt / 2;
          if (j < N) miso_drv = sb[0].mframe[N-1-j];
        end
      end
      if (rsp_valid) begin
        if (sb.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          a = acc_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("latency", cyc - a, e.lat);
          chk("mosi_frame", cap, e.frame);
          chk("edge_count", ecnt, 2 * N);
          chk("first_edge", first_e - a, 1 + e.h);
          chk("ss_n_during", ss_bad, 0);
        end
        rsp_cnt++;
        ecnt = 0; first_e = -1; ss_bad = 0; cap = '0;
      end
      if (ecnt == 0 && sb.size() > 0) miso_drv = sb[0].mframe[N-1];
    end
    sck_prev = sck;
  end

  // Checker for the 3-slave instance (out-of-range index).
  int    ss3_bad = 0, a3 = 0;
  exp3_t e3;
  always @(negedge clk) begin
    if (!rst) begin
      if (busy3 && ss_n3 !== 3'b111) ss3_bad++;
      if (rsp_valid3) begin
        if (sb3.size() == 0 || acc3_q.size() == 0) begin
          chk("unexpected_rsp3", 1, 0);
        end else begin
          e3 = sb3.pop_front();
          a3 = acc3_q.pop_front();
          chk("rsp_rdata3", rsp_rdata3, e3.rdata);
          chk("rsp_err3", rsp_err3, e3.err);
          chk("latency3", cyc - a3, e3.lat);
          chk("ss_n3_during", ss3_bad, 0);
        end
        done3++;
        ss3_bad = 0;
      end
    end
  end

  task automatic send(input logic rw, input logic [6:0] ad, input logic [7:0] wd,
                      input logic [1:0] sl, input logic [1:0] md, input logic [7:0] dv,
                      input logic [7:0] resp, input logic [15:0] fr,
                      input logic [7:0] rd, input logic [3:0] ss, input int lat,
                      input bit hold);
    exp_t x;
    x.frame = fr; x.mframe = {8'h00, resp}; x.rdata = rd; x.err = 1'b0;
    x.lat = lat; x.h = int'(dv) + 1; x.mode = md; x.ss = ss;
    sb.push_back(x);
    @(negedge clk);
    cfg_mode = md; cfg_div = dv;
    repeat (2) @(negedge clk);
    cmd_rw = rw; cmd_addr = ad; cmd_wdata = wd; cmd_slave = sl; cmd_valid = 1'b1;
    for (int i = 0; i < 600 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 3000 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  int rc_before;
  exp3_t y;
  exp_t  z;
  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_ss_n", ss_n, 4'hF);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 0, fastest divider, write to slave 2.
    send(1'b0, 7'h15, 8'hA5, 2'd2, 2'd0, 8'd0, 8'h5A, 16'h15A5, 8'h5A, 4'b1011, 34, 1'b0);
    wait_done();

    // Mode 3, divider 3, read from slave 0.
    send(1'b1, 7'h7F, 8'h00, 2'd0, 2'd3, 8'd3, 8'h3C, 16'hFF00, 8'h3C, 4'b1110, 133, 1'b0);
    wait_done();
    chk("idle_sck_cpol1", sck, 1);
    chk("idle_mosi", mosi, 0);
    cfg_mode = 2'd0;
    repeat (2) @(negedge clk);
    chk("idle_sck_cpol0", sck, 0);

    // Modes 1 and 2 with loopback.
    loop_en = 1'b1;
    send(1'b0, 7'h01, 8'hC3, 2'd1, 2'd1, 8'd1, 8'h00, 16'h01C3, 8'hC3, 4'b1101, 67, 1'b0);
    wait_done();
    send(1'b0, 7'h40, 8'hC3, 2'd3, 2'd2, 8'd2, 8'h00, 16'h40C3, 8'hC3, 4'b0111, 100, 1'b0);
    wait_done();
    loop_en = 1'b0;

    // Out-of-range slave on the 3-slave instance.
    cfg_mode = 2'd0; cfg_div = 8'd0; cmd_rw = 1'b0; cmd_addr = 7'h15; cmd_wdata = 8'hA5;
    repeat (2) @(negedge clk);
    y.rdata = 8'hA5; y.err = 1'b1; y.lat = 34;
    sb3.push_back(y);
    c3_slave = 2'd3; c3_valid = 1'b1;
    for (int i = 0; i < 100 && !cmd_ready3; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    c3_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("dut3_busy_mid", busy3, 1);
    chk("dut3_ss_n_mid", ss_n3, 3'b111);
    for (int i = 0; i < 200 && done3 == 0; i++) @(negedge clk);
    chk("dut3_done", done3, 1);

    // Back-to-back commands, cfg_mode changed during the first.
    send(1'b0, 7'h2A, 8'h0F, 2'd1, 2'd0, 8'd0, 8'h81, 16'h2A0F, 8'h81, 4'b1101, 34, 1'b1);
    z.frame = 16'hB300; z.mframe = 16'h00E7; z.rdata = 8'hE7; z.err = 1'b0;
    z.lat = 34; z.h = 1; z.mode = 2'd3; z.ss = 4'b1011;
    sb.push_back(z);
    cmd_rw = 1'b1; cmd_addr = 7'h33; cmd_wdata = 8'h00; cmd_slave = 2'd2; cfg_mode = 2'd3;
    begin : wait_first
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #1;
        if (rsp_valid) disable wait_first;
      end
    end
    chk("b2b_rsp_seen", rsp_valid, 1);
    chk("b2b_gap_ss_n", ss_n, 4'hF);
    chk("b2b_gap_ready", cmd_ready, 1);
    @(posedge clk); #1;
    chk("b2b_second_ss_n", ss_n, 4'b1011);
    chk("b2b_second_busy", busy, 1);
    cmd_valid = 1'b0;
    wait_done();

    // Reset during a transfer.
    cfg_mode = 2'd0;
    send(1'b0, 7'h11, 8'h22, 2'd0, 2'd0, 8'd1, 8'h00, 16'h1122, 8'h00, 4'b1110, 67, 1'b0);
    begin : wait_edge10
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (ecnt == 10) disable wait_edge10;
      end
    end
    chk("edge10_reached", ecnt, 10);
    rc_before = rsp_cnt;
    rst = 1'b1;
    #1;
    chk("rst_mid_ss_n", ss_n, 4'hF);
    chk("rst_mid_sck", sck, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("no_rsp_after_rst", rsp_cnt, rc_before);

    // Normal read after the reset.
    send(1'b1, 7'h00, 8'h00, 2'd3, 2'd0, 8'd0, 8'h99, 16'h8000, 8'h99, 4'b0111, 34, 1'b0);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_gen.md
# spi_master_gen

Parametrised SPI master: next generation of the single-slave master. Accepts address/data commands over a valid/ready handshake and drives any of NSLAVES chip selects. Supports all four CPOL/CPHA modes and a runtime SCK divider, and returns read data with a one-cycle response pulse. Sits between the command driver and the slave bus.

## Interface
Parameters:
- DWIDTH, 8: data field width in bits.
- AWIDTH, 7: address field width in bits.
- NSLAVES, 4: number of chip selects; SW = $clog2(NSLAVES), minimum 1.
- DIVW, 8: width of the divider configuration.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command (high only in IDLE).
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_addr  in  AWIDTH  slave register address.
- cmd_wdata  in  DWIDTH  write data.
- cmd_slave  in  SW  target slave index.
- cfg_mode  in  2  {CPOL, CPHA}.
- cfg_div  in  DIVW  half-period length minus one, in clk cycles.
- rsp_valid  out  1  one-cycle pulse at transfer end.
- rsp_rdata  out  DWIDTH  MISO bits sampled during the data phase.
- rsp_err  out  1  valid with rsp_valid: cmd_slave >= NSLAVES.
- busy  out  1  high from accept until rsp_valid.
- sck  out  1  serial clock.
- mosi  out  1  serial out.
- miso  in  1  serial in.
- ss_n  out  NSLAVES  active-low chip selects.

## Operation
- Frame: N = 1+AWIDTH+DWIDTH bits, MSB first, in the order {rw, addr, data}.
  - On a write, the data phase carries cmd_wdata.
  - On a read, mosi = 0 during the data phase.
- Accept: a command is accepted on the cycle with cmd_valid && cmd_ready.
  - cmd fields, cfg_mode and cfg_div are latched at accept.
  - Changes to cfg_* during a transfer have no effect on that transfer.
- H = cfg_div+1 clk cycles per SCK half period.
- States: IDLE -> SETUP (H cycles) -> XFER (2N half periods) -> HOLD (H cycles) -> IDLE.
- SETUP:
  - ss_n[cmd_slave] low; sck = CPOL.
  - CPHA=0: mosi = bit N-1.
  - CPHA=1: mosi = 0.
- XFER: one SCK edge at the start of each half period.
  - CPHA=0: sample miso on odd (leading) edges; shift mosi on even (trailing) edges, except after the last bit.
  - CPHA=1: drive on leading edges; sample on trailing edges.
- Only the last DWIDTH samples are kept in rsp_rdata. Writes also capture (full duplex).
- HOLD: sck = CPOL and ss_n stays low. On exit, ss_n goes all ones and the state returns to IDLE.
- rsp_valid pulses in the first IDLE cycle. rsp_rdata and rsp_err hold their values until the next rsp_valid.
- cmd_slave >= NSLAVES: the transfer runs with identical timing, no ss_n bit is asserted, and rsp_err = 1.
- IDLE: sck = registered cfg_mode[1], mosi = 0.

## Timing
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, sck=0, mosi=0, ss_n all ones, state IDLE.
- Accept at cycle 0:
  - ss_n falls at cycle 1.
  - Edge k (k=1..2N) occurs at cycle 1+k·H.
  - ss_n rises and rsp_valid pulses at cycle 1+(2N+1)·H.
- The rsp_valid cycle has cmd_ready=1.
  - If cmd_valid is already high, the next accept happens that cycle.
  - ss_n is therefore high for at least 1 cycle between back-to-back transfers.
- cfg_div=0 gives sck = clk/2. All outputs are registered; miso is sampled in the clk cycle of the edge.
- rst mid-transfer: all outputs return to reset values immediately, the command is dropped, and no rsp_valid is issued.

## Structure
- spi_pkg adds:
  - the state enum (IDLE, SETUP, XFER, HOLD);
  - the mode typedef {cpol, cphase};
  - the constant FRAME_W = 1+AWIDTH+DWIDTH.
- Existing DWIDTH/AWIDTH/NSLAVES defaults stay in spi_pkg.
- Sub-module spi_clkgen contains:
  - the half-period counter (DIVW bits);
  - the edge counter ($clog2(2·FRAME_W+1) bits);
  - lead_stb and trail_stb outputs.
- The top level holds the FSM, shift registers and chip-select decode.

## Test plan
All scenarios use AWIDTH=7, DWIDTH=8 (N=16) unless noted.
1. Mode 0, cfg_div=0, write, slave 2, addr 0x15, data 0xA5 -> ss_n=4'b1011 during the transfer; mosi sampled on sck rising = 0_0010101_10100101; rsp_valid 34 cycles after accept.
2. Mode 3, cfg_div=3, read, slave 0, addr 0x7F; slave model returns 0x3C -> sck idles high; mosi data phase all 0; rsp_rdata=0x3C; rsp_valid 133 cycles after accept.
3. Modes 1 and 2 with mosi looped to miso, write 0xC3 -> rsp_rdata=0xC3 in both modes; no edge before the end of SETUP.
4. NSLAVES=3, cmd_slave=3 -> ss_n stays 3'b111 throughout; rsp_err=1 with rsp_valid; timing identical to scenario 1.
5. cmd_valid held high for two commands; cfg_mode toggled 0->3 mid-transfer -> the first transfer completes in mode 0; ss_n high exactly 1 cycle between transfers; the second transfer runs in mode 3.
6. rst asserted at edge 10 of a transfer -> ss_n all ones, sck=0 and busy=0 within the same cycle; no rsp_valid; the next command completes normally.
